// File: rtl/ucca_region_ctrl.sv
// Region table and steering controller for the UCCA region monitor.
// Programs NREG regions, validates them on lock, then steers one region's bounds from the PC.
module ucca_region_ctrl #(
    parameter int unsigned NREG          = 4,
    parameter logic [15:0] CONF_BASE     = 16'h0160,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    localparam int unsigned IW           = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          system_reset,
    input  logic [15:0]   pc,
    input  logic          data_en,
    input  logic          data_wr,
    input  logic [15:0]   data_addr,
    input  logic [15:0]   data_wdata,
    output logic [15:0]   ucc_min,
    output logic [15:0]   ucc_max,
    output logic [IW-1:0] region_idx,
    output logic          region_active,
    output logic          locked,
    output logic          reset
);

    typedef enum logic [1:0] {StUnlocked, StCheck, StLocked, StFault} state_e;

    state_e          state_q, state_d;
    logic [15:0]     min_q [NREG];
    logic [15:0]     max_q [NREG];
    logic [NREG-1:0] en_q;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   cur_q, cur_d;
    logic            inside_q, inside_d;

    // Address decode works on word addresses; byte bit 0 is ignored.
    logic            wr_en;
    logic [14:0]     addr_w;
    logic [14:0]     base_w;
    logic [14:0]     word;
    logic            in_win;
    logic            ctrl_sel;
    logic            min_sel;
    logic            max_sel;
    logic [IW-1:0]   slot;
    logic            lock_req;
    logic [NREG-1:0] new_en;
    logic            unused_bits;

    assign wr_en    = data_en & data_wr;
    assign addr_w   = data_addr[15:1];
    assign base_w   = CONF_BASE[15:1];
    assign word     = addr_w - base_w;
    assign in_win   = wr_en && (addr_w >= base_w) && (word <= 15'(2 * NREG));
    assign ctrl_sel = in_win && (word == 15'd0);
    assign min_sel  = in_win && word[0];
    assign max_sel  = in_win && (word != 15'd0) && !word[0];
    assign slot     = IW'((word - 15'd1) >> 1);
    assign lock_req = ctrl_sel && data_wdata[0];
    assign new_en   = data_wdata[8 +: NREG];

    assign unused_bits = ^{RESET_HANDLER, CONF_BASE[0], data_addr[0], data_wdata};

    // Validation of slot cnt_q: inverted range or inclusive overlap with an earlier enabled slot.
    logic chk_fail;
    always_comb begin
        chk_fail = 1'b0;
        if (en_q[cnt_q]) begin
            if (min_q[cnt_q] > max_q[cnt_q]) chk_fail = 1'b1;
            for (int j = 0; j < NREG; j++) begin
                if ((IW'(j) < cnt_q) && en_q[j] &&
                    (min_q[cnt_q] <= max_q[j]) && (min_q[j] <= max_q[cnt_q])) begin
                    chk_fail = 1'b1;
                end
            end
        end
    end

    logic [NREG-1:0] hit;
    logic            any_hit;
    logic            hit_cur;
    logic [IW-1:0]   m_idx;
    logic [IW-1:0]   steer;

    always_comb begin
        hit   = '0;
        m_idx = '0;
        for (int j = 0; j < NREG; j++) begin
            hit[j] = en_q[j] && (pc >= min_q[j]) && (pc <= max_q[j]);
        end
        for (int j = NREG - 1; j >= 0; j--) begin
            if (hit[j]) m_idx = IW'(j);
        end
    end

    assign any_hit = |hit;
    assign hit_cur = hit[cur_q];
    // Outside any region the last region stays steered so the monitor keeps a stable window.
    assign steer   = (inside_q || !any_hit) ? cur_q : m_idx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        inside_d = inside_q;
        unique case (state_q)
            StUnlocked: begin
                if (lock_req) begin
                    cnt_d   = '0;
                    state_d = (new_en == '0) ? StFault : StCheck;
                end
            end
            StCheck: begin
                if (in_win || chk_fail) begin
                    state_d = StFault;
                end else if (cnt_q == IW'(NREG - 1)) begin
                    state_d = StLocked;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLocked: begin
                inside_d = any_hit;
                if (any_hit && !inside_q) cur_d = m_idx;
                // Leaving a region must pass through non-region code first.
                if (in_win || (inside_q && any_hit && !hit_cur)) state_d = StFault;
            end
            StFault: begin
            end
            default: state_d = StFault;
        endcase
    end

    always_ff @(posedge clk) begin
        if (system_reset) begin
            state_q  <= StUnlocked;
            cnt_q    <= '0;
            cur_q    <= '0;
            inside_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            inside_q <= inside_d;
        end
    end

    always_ff @(posedge clk) begin
        if (system_reset) begin
            en_q <= '0;
            for (int j = 0; j < NREG; j++) begin
                min_q[j] <= '0;
                max_q[j] <= '0;
            end
        end else if (state_q == StUnlocked) begin
            if (ctrl_sel) en_q <= new_en;
            if (min_sel) min_q[slot] <= data_wdata;
            if (max_sel) max_q[slot] <= data_wdata;
        end
    end

    always_comb begin
        locked        = (state_q == StLocked);
        reset         = (state_q == StFault);
        region_idx    = cur_q;
        ucc_min       = 16'hFFFF;
        ucc_max       = 16'h0000;
        region_active = 1'b0;
        if (state_q == StLocked) begin
            region_idx    = steer;
            ucc_min       = min_q[steer];
            ucc_max       = max_q[steer];
            region_active = inside_q ? hit_cur : any_hit;
        end
    end

endmodule
